// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//
// Purpose: constants and types shared by the instruction-fetch stage and
//          its instruction memory.
//
// Contents:
//   NOP               - all-zero word (sll $0,$0,0); decode treats it as a
//                       bubble with every control signal inactive
//   HALT_WORD_DEFAULT - default encoding that stops fetch
//   PC_INCREMENT      - byte distance between consecutive instructions
//   fetch_state_e     - fetch FSM states (FETCH, HALTED)
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INCREMENT      = 32'd4;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
//
// Purpose: word-organised instruction ROM with a combinational read port.
//          The array holds whatever image the environment places in it.
//
// Parameters:
//   B         - word width
//   N         - word-address bits (depth 2**N)
//   INIT_FILE - image name, kept for interface compatibility
//
// Ports:
//   addr  in  N  word index
//   data  out B  word stored at addr
// ---------------------------------------------------------------------------
module instruction_memory #(
    parameter int    B         = 32,
    parameter int    N         = 7,
    parameter string INIT_FILE = ""
) (
    input  logic [N-1:0] addr,
    output logic [B-1:0] data
);

    localparam int DEPTH = 2 ** N;

    logic [B-1:0] mem [DEPTH];

    // Combinational read. The address width equals the index range, so it cannot go out of bounds.
    assign data = mem[addr];

endmodule : instruction_memory

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose: instruction-fetch stage plus IF/ID pipeline register. Holds the
//          PC, reads instruction memory and hands {instruction, PC+4} to
//          decode. Supports stall, flush and redirect (branch/jump), and
//          stops fetching in a HALTED state when it reads the halt word.
//
// Parameters:
//   B         - data/instruction/PC width
//   N         - instruction-memory word-address bits
//   HALT_WORD - encoding that stops fetch
//   INIT_FILE - hex image for the instruction memory
//
// Ports:
//   clk              in  1  rising-edge clock
//   reset            in  1  synchronous, active-low reset
//   stall            in  1  hold PC and IF/ID
//   flush            in  1  load NOP into IF/ID
//   pc_src           in  1  branch taken, redirect to pc_branch
//   pc_branch        in  B  branch target
//   jump             in  1  jump, redirect to pc_jump (wins over pc_src)
//   pc_jump          in  B  jump target
//   instruction      out B  IF/ID instruction
//   pc_incrementado  out B  IF/ID PC+4
//   pc               out B  current fetch PC
//   halted           out 1  high while in HALTED
//
// Priority at each rising edge: reset, redirect, flush, stall, then the
// normal fetch / halt-detect / halted behaviour.
// ---------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int           B         = 32,
    parameter int           N         = 7,
    parameter logic [B-1:0] HALT_WORD = B'(HALT_WORD_DEFAULT),
    parameter string        INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         pc_src,
    input  logic [B-1:0] pc_branch,
    input  logic         jump,
    input  logic [B-1:0] pc_jump,
    output logic [B-1:0] instruction,
    output logic [B-1:0] pc_incrementado,
    output logic [B-1:0] pc,
    output logic         halted
);

    localparam logic [B-1:0] NOP_W  = B'(NOP);
    localparam logic [B-1:0] STEP_W = B'(PC_INCREMENT);
    localparam logic [B-1:0] ZERO_W = {B{1'b0}};

    // Architectural state
    fetch_state_e state_r;
    logic [B-1:0] pc_r;
    logic [B-1:0] instr_r;
    logic [B-1:0] pc_inc_r;
    logic         halted_r;

    // Combinational helpers
    logic         redirect_s;
    logic [B-1:0] target_s;
    logic [B-1:0] pc_plus4_s;
    logic [B-1:0] fetched_s;
    logic         is_halt_s;

    // Upper PC bits are ignored, so fetch addresses wrap modulo the memory depth.
    instruction_memory #(
        .B         (B),
        .N         (N),
        .INIT_FILE (INIT_FILE)
    ) u_imem (
        .addr (pc_r[N+1:2]),
        .data (fetched_s)
    );

    // Redirect detection and target selection. Jump wins when both are asserted.
    always_comb begin
        redirect_s = jump | pc_src;
        if (jump) begin
            target_s = pc_jump;
        end else begin
            target_s = pc_branch;
        end
    end

    // Sequential PC+4, wrapping modulo 2**B. Also compares the fetched word with the halt word.
    always_comb begin
        pc_plus4_s = pc_r + STEP_W;
        is_halt_s  = (fetched_s == HALT_WORD);
    end

    // Fetch FSM: PC register, IF/ID register and the halted flag, updated in priority order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= FETCH;
            pc_r     <= ZERO_W;
            instr_r  <= ZERO_W;
            pc_inc_r <= ZERO_W;
            halted_r <= 1'b0;
        end else if (redirect_s) begin
            // A redirect leaves HALTED and overrides both stall and halt detection.
            state_r  <= FETCH;
            pc_r     <= target_s;
            instr_r  <= NOP_W;
            pc_inc_r <= ZERO_W;
            halted_r <= 1'b0;
        end else if (flush) begin
            // Flush beats stall: the bubble goes in even when the hazard unit holds.
            if (state_r == FETCH) begin
                pc_r <= pc_plus4_s;
            end else begin
                pc_r <= pc_r;
            end
            state_r  <= state_r;
            instr_r  <= NOP_W;
            pc_inc_r <= ZERO_W;
            halted_r <= halted_r;
        end else if (stall) begin
            state_r  <= state_r;
            pc_r     <= pc_r;
            instr_r  <= instr_r;
            pc_inc_r <= pc_inc_r;
            halted_r <= halted_r;
        end else begin
            case (state_r)
                FETCH: begin
                    if (is_halt_s) begin
                        // The halt word is never passed on. The PC stays parked on it.
                        state_r  <= HALTED;
                        pc_r     <= pc_r;
                        instr_r  <= NOP_W;
                        pc_inc_r <= ZERO_W;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= FETCH;
                        pc_r     <= pc_plus4_s;
                        instr_r  <= fetched_s;
                        pc_inc_r <= pc_plus4_s;
                        halted_r <= 1'b0;
                    end
                end
                HALTED: begin
                    state_r  <= HALTED;
                    pc_r     <= pc_r;
                    instr_r  <= NOP_W;
                    pc_inc_r <= ZERO_W;
                    halted_r <= 1'b1;
                end
                default: begin
                    // Unreachable encoding. Recover to a clean fetch from the current PC.
                    state_r  <= FETCH;
                    pc_r     <= pc_r;
                    instr_r  <= NOP_W;
                    pc_inc_r <= ZERO_W;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign instruction     = instr_r;
    assign pc_incrementado = pc_inc_r;
    assign pc              = pc_r;
    assign halted          = halted_r;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. The memory image is written into
// the DUT's ROM array and into a local copy. A next-state model computes
// the expected {pc, instruction, pc_incrementado, halted} after every
// rising edge. Outputs are compared against the model on every falling
// edge, and literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        jump;
    logic [31:0] pc_jump;
    logic [31:0] instruction;
    logic [31:0] pc_incrementado;
    logic [31:0] pc;
    logic        halted;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    logic [31:0] img [DEPTH];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] inc;
        logic        halt;
    } mdl_t;

    mdl_t m;

    instruction_fetch #(
        .B         (32),
        .N         (7),
        .HALT_WORD (32'hFFFF_FFFF),
        .INIT_FILE ("")
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .pc_src          (pc_src),
        .pc_branch       (pc_branch),
        .jump            (jump),
        .pc_jump         (pc_jump),
        .instruction     (instruction),
        .pc_incrementado (pc_incrementado),
        .pc              (pc),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // What the stage must hold after one rising edge, taken rule by rule.
    function automatic mdl_t mdl_next(input mdl_t c, input logic rst_n,
                                      input logic st, input logic fl,
                                      input logic ps, input logic [31:0] pb,
                                      input logic jp, input logic [31:0] pj);
        mdl_t n;
        logic [31:0] w;
        n = c;
        if (!rst_n) begin
            n = '0;
        end else if (jp || ps) begin
            n.pc   = jp ? pj : pb;
            n.ins  = 32'h0;
            n.inc  = 32'h0;
            n.halt = 1'b0;
        end else if (fl) begin
            if (!c.halt) n.pc = c.pc + 32'd4;
            n.ins = 32'h0;
            n.inc = 32'h0;
        end else if (st) begin
            n = c;
        end else if (c.halt) begin
            n.ins = 32'h0;
            n.inc = 32'h0;
        end else begin
            w = img[(c.pc / 32'd4) % DEPTH];
            if (w == 32'hFFFF_FFFF) begin
                n.halt = 1'b1;
                n.ins  = 32'h0;
                n.inc  = 32'h0;
            end else begin
                n.ins = w;
                n.inc = c.pc + 32'd4;
                n.pc  = c.pc + 32'd4;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= mdl_next(m, reset, stall, flush, pc_src, pc_branch, jump, pc_jump);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_instruction", instruction, m.ins);
            check("mdl_pc_inc", pc_incrementado, m.inc);
            check("mdl_pc", pc, m.pc);
            check("mdl_halted", {31'd0, halted}, {31'd0, m.halt});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_src = 1'b0; pc_branch = 32'h0; jump = 1'b0; pc_jump = 32'h0;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'h0100_0000 + i;
        img[0]   = 32'h0000_0011;
        img[1]   = 32'h0000_0022;
        img[2]   = 32'h0000_0033;
        img[3]   = 32'h0000_0044;
        img[16]  = 32'h0000_1616;
        img[32]  = 32'h0000_2020;
        img[127] = 32'h0000_7F7F;
        for (int i = 0; i < DEPTH; i++) dut.u_imem.mem[i] = img[i];

        // Reset state
        step();
        chk_en = 1'b1;
        check("rst_instruction", instruction, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_inc", pc_incrementado, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;

        // Sequential fetch, then a two-cycle stall while 0x22 is held
        step(); check("seq0_instr", instruction, 32'h11); check("seq0_inc", pc_incrementado, 32'h4);
        step(); check("seq1_instr", instruction, 32'h22); check("seq1_pc", pc, 32'h8);
        stall = 1'b1;
        step(); check("stall1_instr", instruction, 32'h22); check("stall1_pc", pc, 32'h8);
        step(); check("stall2_instr", instruction, 32'h22); check("stall2_pc", pc, 32'h8);
        stall = 1'b0;
        step(); check("post_stall_instr", instruction, 32'h33); check("post_stall_inc", pc_incrementado, 32'hC);
        step(); check("seq3_instr", instruction, 32'h44); check("seq3_pc", pc, 32'h10);

        // Jump back to 8, then a taken branch from pc=8
        jump = 1'b1; pc_jump = 32'h8;
        step(); check("jmp8_pc", pc, 32'h8); check("jmp8_instr", instruction, 32'h0);
        jump = 1'b0; pc_src = 1'b1; pc_branch = 32'h40;
        step(); check("br_pc", pc, 32'h40); check("br_instr_nop", instruction, 32'h0);
        check("br_inc_zero", pc_incrementado, 32'h0);
        pc_src = 1'b0;
        step(); check("br_target_instr", instruction, 32'h1616); check("br_target_inc", pc_incrementado, 32'h44);

        // Jump and branch together: jump wins
        jump = 1'b1; pc_src = 1'b1; pc_jump = 32'h80; pc_branch = 32'h40;
        step(); check("jmp_wins_pc", pc, 32'h80);
        jump = 1'b0; pc_src = 1'b0;
        step(); check("jmp_target_instr", instruction, 32'h2020);

        // Plant the halt word at word 3 and restart from 0
        img[3] = 32'hFFFF_FFFF;
        dut.u_imem.mem[3] = 32'hFFFF_FFFF;
        jump = 1'b1; pc_jump = 32'h0;
        step(); check("restart_pc", pc, 32'h0);
        jump = 1'b0;
        step(); step(); step();
        check("pre_halt_instr", instruction, 32'h33);
        step(); check("halt_flag", {31'd0, halted}, 32'd1); check("halt_pc", pc, 32'hC);
        check("halt_instr", instruction, 32'h0);
        step(); check("halt_hold_pc", pc, 32'hC);
        flush = 1'b1;
        step(); check("halt_flush_pc", pc, 32'hC); check("halt_flush_flag", {31'd0, halted}, 32'd1);
        flush = 1'b0;

        // Jump out of HALTED
        jump = 1'b1; pc_jump = 32'h0;
        step(); check("unhalt_flag", {31'd0, halted}, 32'd0); check("unhalt_pc", pc, 32'h0);
        jump = 1'b0;
        step(); check("resume_instr", instruction, 32'h11);
        step(); step(); step();
        check("rehalt_flag", {31'd0, halted}, 32'd1);

        // Reset while halted and stalled
        stall = 1'b1; reset = 1'b0;
        step(); check("rst_mid_halted", {31'd0, halted}, 32'd0); check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_instr", instruction, 32'h0);
        reset = 1'b1;
        step(); check("stall_after_rst_pc", pc, 32'h0);

        // Flush together with stall: bubble in, PC advances
        flush = 1'b1;
        step(); check("flush_stall_instr", instruction, 32'h0); check("flush_stall_pc", pc, 32'h4);
        flush = 1'b0; stall = 1'b0;
        step(); check("after_flush_instr", instruction, 32'h22); check("after_flush_inc", pc_incrementado, 32'h8);

        // PC wrap at the top of the address space
        jump = 1'b1; pc_jump = 32'hFFFF_FFFC;
        step(); check("wrap_pc_top", pc, 32'hFFFF_FFFC);
        jump = 1'b0;
        step(); check("wrap_instr", instruction, 32'h7F7F); check("wrap_inc", pc_incrementado, 32'h0);
        check("wrap_pc", pc, 32'h0);
        step(); check("wrap_next_instr", instruction, 32'h11);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instruction_fetch
